// File: rtl/ads8681_pkg.sv
// Shared types and constants for the ADS8681 acquisition sequencer.
package ads8681_pkg;

  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } state_t;

  // Shortest tick period that never collides with a busy frame:
  // tick cycle + conversion + 16 SCLK periods + DONE cycle.
  function automatic int min_period(input int conv_cycles, input int sclk_div);
    return conv_cycles + 32 * sclk_div + 2;
  endfunction

endpackage

// File: rtl/ads8681_acq_ctrl_if.sv
// Word stream towards the PSSI transmitter.
// Handshake: a word transfers on every clock edge where word_valid_o and
// word_ready_i are both high; while word_valid_o is high and the word has not
// transferred, word_o and word_valid_o hold steady; ready may toggle freely.
interface ads8681_acq_ctrl_if;
  import ads8681_pkg::*;

  logic [WORD_W-1:0] word_o;
  logic              word_valid_o;
  logic              word_ready_i;

  modport master (output word_o, output word_valid_o, input word_ready_i);
  modport slave  (input word_o, input word_valid_o, output word_ready_i);

endinterface

// File: rtl/ads8681_spi_rx.sv
// SPI mode-0 reader: 16 SCLK periods, MSB first, sampled on each rising SCLK.
module ads8681_spi_rx
  import ads8681_pkg::*;
#(
  parameter int SCLK_DIV = 2
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic                sdo_i,
  output logic                sclk_o,
  output logic                done_o,
  output logic [SAMPLE_W-1:0] sample_o
);

  localparam int               DIV_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

  logic                active_q, active_d;
  logic                sclk_q, sclk_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [4:0]          half_q, half_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;

  // Half-period divider; every divider wrap toggles SCLK, rising toggles shift in.
  always_comb begin
    active_d = active_q;
    sclk_d   = sclk_q;
    div_d    = div_q;
    half_d   = half_q;
    shift_d  = shift_q;
    done_o   = 1'b0;
    if (start_i && !active_q) begin
      active_d = 1'b1;
      sclk_d   = 1'b0;
      div_d    = '0;
      half_d   = '0;
    end else if (active_q) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
        half_d = half_q + 5'd1;
        if (!sclk_q) begin
          shift_d = {shift_q[SAMPLE_W-2:0], sdo_i};
        end
        // The 32nd toggle returns SCLK low and closes the frame.
        if (half_q == 5'd31) begin
          active_d = 1'b0;
          done_o   = 1'b1;
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // Register update; reset aborts any frame in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      div_q    <= '0;
      half_q   <= '0;
      shift_q  <= '0;
    end else begin
      active_q <= active_d;
      sclk_q   <= sclk_d;
      div_q    <= div_d;
      half_q   <= half_d;
      shift_q  <= shift_d;
    end
  end

  assign sclk_o   = sclk_q;
  assign sample_o = shift_q;

endmodule

// File: rtl/ads8681_acq_ctrl.sv
// ADS8681 acquisition sequencer: periodic CONVST, SPI read, pair packing,
// valid/ready word output and sticky overrun reporting.
module ads8681_acq_ctrl
  import ads8681_pkg::*;
#(
  parameter int CONV_CYCLES = 40,
  parameter int SCLK_DIV    = 2,
  parameter int PERIOD_W    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic [PERIOD_W-1:0]  period_i,
  input  logic                 overrun_clr_i,
  output logic                 adc_convst_o,
  output logic                 adc_sclk_o,
  input  logic                 adc_sdo_i,
  ads8681_acq_ctrl_if.master   wb,
  output logic                 busy_o,
  output logic                 overrun_o,
  output state_t               state_o
);

  localparam int             CNT_W     = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PERIOD_W-1:0]  timer_q, timer_d;
  logic                 convst_q;
  logic                 half_q, half_d;
  logic [SAMPLE_W-1:0]  low_q, low_d;
  logic [WORD_W-1:0]    word_q, word_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;
  logic                 tick, spi_start, spi_done, ovr_set, take;
  logic [SAMPLE_W-1:0]  sample;

  ads8681_spi_rx #(.SCLK_DIV(SCLK_DIV)) u_spi_rx (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .start_i  (spi_start),
    .sdo_i    (adc_sdo_i),
    .sclk_o   (adc_sclk_o),
    .done_o   (spi_done),
    .sample_o (sample)
  );

  assign tick = en_i && (timer_q == '0);

  // Period timer: held at 0 while disabled, reloads with max(period,2)-1 on tick.
  always_comb begin
    timer_d = timer_q;
    if (!en_i) begin
      timer_d = '0;
    end else if (tick) begin
      timer_d = (period_i < PERIOD_W'(2)) ? PERIOD_W'(1) : period_i - PERIOD_W'(1);
    end else begin
      timer_d = timer_q - PERIOD_W'(1);
    end
  end

  // Frame sequencing: IDLE -> CONV (CONV_CYCLES) -> READ (SPI) -> DONE -> IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    spi_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = CONV;
          cnt_d   = '0;
        end
      end
      CONV: begin
        if (cnt_q == CONV_LAST) begin
          state_d   = READ;
          spi_start = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      READ: begin
        if (spi_done) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pair packing, output holding register and overrun detection.
  always_comb begin
    half_d  = half_q;
    low_d   = low_q;
    word_d  = word_q;
    valid_d = valid_q;
    ovr_set = 1'b0;
    take    = valid_q && wb.word_ready_i;
    if (take) valid_d = 1'b0;
    if (state_q == DONE) begin
      if (!half_q) begin
        low_d  = sample;
        half_d = 1'b1;
      end else begin
        half_d = 1'b0;
        // A full word only lands if the holding register is free this cycle.
        if (!valid_q || take) begin
          word_d  = {sample, low_q};
          valid_d = 1'b1;
        end else begin
          ovr_set = 1'b1;
        end
      end
    end
    // A lone first sample never pairs across a disable.
    if (state_q == IDLE && !en_i) half_d = 1'b0;
    if (tick && state_q != IDLE) ovr_set = 1'b1;
    overrun_d = ovr_set ? 1'b1 : (overrun_clr_i ? 1'b0 : overrun_q);
  end

  // State and datapath registers; reset aborts the frame and clears all outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timer_q   <= '0;
      convst_q  <= 1'b0;
      half_q    <= 1'b0;
      low_q     <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      convst_q  <= (state_d == CONV);
      half_q    <= half_d;
      low_q     <= low_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign adc_convst_o    = convst_q;
  assign wb.word_o       = word_q;
  assign wb.word_valid_o = valid_q;
  assign busy_o          = (state_q != IDLE);
  assign overrun_o       = overrun_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_ads8681_acq_ctrl.sv
// Directed bench for ads8681_acq_ctrl with an ADC model and word scoreboard.
module tb_ads8681_acq_ctrl;
  import ads8681_pkg::*;

  localparam int CONV_CYCLES = 4;
  localparam int SCLK_DIV    = 2;
  localparam int PERIOD_W    = 16;

  // ---------------- clock / reset / signals ----------------
  logic                clk = 1'b0;
  logic                rst_n;
  logic                en;
  logic [PERIOD_W-1:0] period;
  logic                ovr_clr;
  logic                convst, sclk, sdo, busy, overrun;
  state_t              state;

  ads8681_acq_ctrl_if wif();

  always #5 clk = ~clk;

  ads8681_acq_ctrl #(
    .CONV_CYCLES (CONV_CYCLES),
    .SCLK_DIV    (SCLK_DIV),
    .PERIOD_W    (PERIOD_W)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .en_i          (en),
    .period_i      (period),
    .overrun_clr_i (ovr_clr),
    .adc_convst_o  (convst),
    .adc_sclk_o    (sclk),
    .adc_sdo_i     (sdo),
    .wb            (wif),
    .busy_o        (busy),
    .overrun_o     (overrun),
    .state_o       (state)
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [15:0] adc_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- ADC model and frame monitor ----------------
  logic [15:0] adc_cur = 16'h0;
  int          adc_idx = 16;
  assign sdo = (adc_idx < 16) ? adc_cur[4'(15 - adc_idx)] : 1'b0;

  logic prev_convst = 1'b0;
  logic prev_sclk   = 1'b0;
  int   cyc = 0, last_start = -1, hi_run = 0, rise_cnt = 0, idle_run = 0, frames = 0;
  int   exp_gap = 0;
  bit   check_idle = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!en) last_start = -1;
    if (convst && !prev_convst) begin
      if (last_start >= 0 && exp_gap != 0) check("frame_gap", cyc - last_start, exp_gap);
      if (last_start >= 0 && check_idle) check("idle_len", idle_run, 1);
      last_start = cyc;
      idle_run   = 0;
      rise_cnt   = 0;
      frames++;
      adc_cur = (adc_q.size() != 0) ? adc_q.pop_front() : 16'h0;
      adc_idx = 0;
    end
    if (convst) hi_run++;
    if (!convst && prev_convst) begin
      check("convst_len", hi_run, CONV_CYCLES);
      hi_run = 0;
    end
    if (sclk && !prev_sclk) begin
      rise_cnt++;
      adc_idx++;
    end
    if (state == DONE) check("sclk_rises", rise_cnt, 16);
    if (state == IDLE) idle_run++;
    // Transfer happens at the coming edge.
    if (wif.word_valid_o === 1'b1 && wif.word_ready_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL word_unexpected: observed 0x%0h expected no word", wif.word_o);
        end
      end else begin
        check("word", wif.word_o, exp_q.pop_front());
      end
    end
    prev_convst = convst;
    prev_sclk   = sclk;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_word"},    wif.word_o, 32'h0);
    check({tag, "_valid"},   32'(wif.word_valid_o), 32'h0);
    check({tag, "_convst"},  32'(convst), 32'h0);
    check({tag, "_sclk"},    32'(sclk), 32'h0);
    check({tag, "_busy"},    32'(busy), 32'h0);
    check({tag, "_overrun"}, 32'(overrun), 32'h0);
    check({tag, "_state"},   32'(state), 32'(IDLE));
  endtask

  task automatic clear_overrun();
    ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          f0;
    logic [15:0] a, b;

    rst_n = 1'b0; en = 1'b0; period = 16'd100; ovr_clr = 1'b0;
    wif.word_ready_i = 1'b1;
    step(3);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    step(2);

    // Basic pair
    adc_q.push_back(16'h1234); adc_q.push_back(16'hABCD);
    exp_q.push_back(32'hABCD1234);
    exp_gap = 100; f0 = frames;
    en = 1'b1; step(180); en = 1'b0; step(5);
    check("t1_frames", frames - f0, 2);
    check("t1_drained", exp_q.size(), 0);
    check("t1_valid", 32'(wif.word_valid_o), 0);
    check("t1_overrun", 32'(overrun), 0);

    // Backpressure: only the first of three words survives
    adc_q.push_back(16'h1111); adc_q.push_back(16'h2222);
    adc_q.push_back(16'h3333); adc_q.push_back(16'h4444);
    adc_q.push_back(16'h5555); adc_q.push_back(16'h6666);
    exp_q.push_back(32'h22221111);
    wif.word_ready_i = 1'b0; f0 = frames;
    en = 1'b1; step(180);
    check("t2_valid_first", 32'(wif.word_valid_o), 1);
    check("t2_word_first", wif.word_o, 32'h22221111);
    check("t2_overrun_early", 32'(overrun), 0);
    step(410); en = 1'b0; step(5);
    check("t2_frames", frames - f0, 6);
    check("t2_valid_held", 32'(wif.word_valid_o), 1);
    check("t2_word_held", wif.word_o, 32'h22221111);
    check("t2_overrun", 32'(overrun), 1);
    wif.word_ready_i = 1'b1; step(1);
    check("t2_valid_drop", 32'(wif.word_valid_o), 0);
    check("t2_drained", exp_q.size(), 0);
    check("t2_overrun_sticky", 32'(overrun), 1);
    clear_overrun();
    check("t2_overrun_clr", 32'(overrun), 0);

    // Period too short: every other tick dropped
    period = 16'd50; exp_gap = 100; f0 = frames;
    adc_q.push_back(16'h0A0A); adc_q.push_back(16'h0B0B);
    adc_q.push_back(16'h0C0C); adc_q.push_back(16'h0D0D);
    exp_q.push_back(32'h0B0B0A0A); exp_q.push_back(32'h0D0D0C0C);
    en = 1'b1; step(390); en = 1'b0; step(5);
    check("t3_frames", frames - f0, 4);
    check("t3_drained", exp_q.size(), 0);
    check("t3_overrun", 32'(overrun), 1);
    clear_overrun();
    check("t3_overrun_clr", 32'(overrun), 0);

    // Boundary period: back-to-back frames, single IDLE cycle, no overrun
    period = PERIOD_W'(min_period(CONV_CYCLES, SCLK_DIV));
    exp_gap = min_period(CONV_CYCLES, SCLK_DIV); check_idle = 1'b1; f0 = frames;
    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      adc_q.push_back(a); adc_q.push_back(b);
      exp_q.push_back({b, a});
    end
    en = 1'b1; step(20 * min_period(CONV_CYCLES, SCLK_DIV)); en = 1'b0; check_idle = 1'b0;
    step(5);
    check("t4_frames", frames - f0, 20);
    check("t4_drained", exp_q.size(), 0);
    check("t4_overrun", 32'(overrun), 0);

    // Disable after a lone first sample: the half is discarded
    period = 16'd100; exp_gap = 100; f0 = frames;
    adc_q.push_back(16'h7777);
    en = 1'b1; step(75); en = 1'b0; step(5);
    check("t5_frames_half", frames - f0, 1);
    check("t5_no_word", 32'(wif.word_valid_o), 0);
    adc_q.push_back(16'h0001); adc_q.push_back(16'h0002);
    exp_q.push_back(32'h00020001);
    en = 1'b1; step(180); en = 1'b0; step(5);
    check("t5_frames", frames - f0, 3);
    check("t5_drained", exp_q.size(), 0);

    // Reset in the middle of READ
    adc_q.push_back(16'h5A5A);
    en = 1'b1; step(20);
    check("t6_in_read", 32'(state), 32'(READ));
    rst_n = 1'b0; en = 1'b0; step(1);
    check_zero_outputs("t6_reset");
    rst_n = 1'b1;
    adc_q.push_back(16'h0102); adc_q.push_back(16'h0304);
    exp_q.push_back(32'h03040102);
    f0 = frames;
    en = 1'b1; step(180); en = 1'b0; step(5);
    check("t6_frames", frames - f0, 2);
    check("t6_drained", exp_q.size(), 0);
    check("t6_overrun", 32'(overrun), 0);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
